// File: rtl/sprite_pkg.sv
// sprite_pkg: shared scanline geometry, pixel types and line buffer FSM states.
package sprite_pkg;
    localparam int H_ACTIVE = 640;
    localparam int PIX_W = 16;
    typedef logic [PIX_W-1:0] pixel_t;
    typedef logic [9:0] col_t;
    localparam pixel_t TRANSPARENT = '0;
    localparam col_t COL_END = col_t'(H_ACTIVE);
    localparam col_t LAST_COL = col_t'(H_ACTIVE - 1);
    typedef enum logic {LB_INIT, LB_RUN} lb_state_t;
    function automatic logic in_range(col_t c);
        return c < COL_END;
    endfunction
endpackage

// File: rtl/sprite_line_buffer_if.sv
// sprite_line_buffer_if: drawer, scanout and status signals of the sprite line buffer.
interface sprite_line_buffer_if;
    import sprite_pkg::*;
    logic line_swap;
    logic draw_done;
    logic wr_en;
    col_t wr_col;
    pixel_t wr_data;
    logic rd_en;
    col_t rd_col;
    pixel_t rd_data;
    logic rd_opaque;
    logic ready;
    logic overrun;
    modport master (
        output line_swap, draw_done, wr_en, wr_col, wr_data, rd_en, rd_col,
        input rd_data, rd_opaque, ready, overrun
    );
    modport slave (
        input line_swap, draw_done, wr_en, wr_col, wr_data, rd_en, rd_col,
        output rd_data, rd_opaque, ready, overrun
    );
endinterface

// File: rtl/line_bank_ram.sv
// line_bank_ram: one scanline bank, single write port and registered read port, no content reset.
module line_bank_ram
    import sprite_pkg::*;
(
    input logic clk,
    input logic we,
    input col_t wa,
    input pixel_t wd,
    input col_t ra,
    output pixel_t rq
);
    pixel_t mem [H_ACTIVE];
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        rq <= mem[ra];
    end
endmodule

// File: rtl/sprite_line_buffer.sv
// sprite_line_buffer: ping-pong scanline buffer between sprite_engine and the compositor.
// Draw bank = bank_sel, display bank = ~bank_sel; displayed pixels are cleared after read.
module sprite_line_buffer
    import sprite_pkg::*;
(
    input logic clk,
    input logic reset,
    sprite_line_buffer_if.slave bus
);
    lb_state_t state;
    col_t clr_col;
    col_t rd_col_q;
    logic bank_sel;
    logic seen_done;
    logic rd_hit_q;
    logic rd_bank_q;
    logic overrun_q;
    logic run;
    logic draw_ok;
    logic clr_ok;
    pixel_t q [2];

    assign run = state == LB_RUN;
    assign draw_ok = run && bus.wr_en && in_range(bus.wr_col) && bus.wr_data != TRANSPARENT;
    // a read that coincided with line_swap would clear the new draw bank; drop that clear
    assign clr_ok = run && rd_hit_q && rd_bank_q != bank_sel;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic we;
        col_t wa;
        pixel_t wd;
        logic is_draw;
        always_comb begin
            is_draw = bank_sel == 1'(b);
            we = !run || (is_draw ? draw_ok : clr_ok && rd_bank_q == 1'(b));
            wa = !run ? clr_col : is_draw ? bus.wr_col : rd_col_q;
            wd = (run && is_draw) ? bus.wr_data : TRANSPARENT;
        end
        line_bank_ram u_ram (
            .clk(clk),
            .we(we),
            .wa(wa),
            .wd(wd),
            .ra(bus.rd_col),
            .rq(q[b])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LB_INIT;
            clr_col <= '0;
            rd_col_q <= '0;
            bank_sel <= 1'b0;
            seen_done <= 1'b0;
            rd_hit_q <= 1'b0;
            rd_bank_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            rd_hit_q <= run && bus.rd_en && in_range(bus.rd_col);
            rd_bank_q <= ~bank_sel;
            rd_col_q <= bus.rd_col;
            overrun_q <= run && bus.line_swap && !seen_done && !bus.draw_done;
            if (!run) begin
                if (clr_col == LAST_COL) state <= LB_RUN;
                else clr_col <= clr_col + 1'b1;
            end else if (bus.line_swap) begin
                bank_sel <= ~bank_sel;
                seen_done <= 1'b0;
            end else if (bus.draw_done) begin
                seen_done <= 1'b1;
            end
        end
    end

    assign bus.rd_data = rd_hit_q ? q[rd_bank_q] : TRANSPARENT;
    assign bus.rd_opaque = bus.rd_data != TRANSPARENT;
    assign bus.ready = run;
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_sprite_line_buffer.sv
// tb_sprite_line_buffer: table-driven directed vectors plus randomized line traffic
// checked against an array-based model of the two scanline banks.
module tb_sprite_line_buffer;
    import sprite_pkg::*;

    typedef struct {
        logic sw, dn, we;
        col_t wc;
        pixel_t wd;
        logic re;
        col_t rc;
        pixel_t ed;
        logic eo, ev;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    sprite_line_buffer_if bus();
    sprite_line_buffer dut (.clk(clk), .reset(reset), .bus(bus.slave));

    int errs = 0;
    int checks = 0;
    pixel_t mb [2][H_ACTIVE];
    logic m_sel, m_seen, p_v, p_b;
    col_t p_c;
    int m_cnt;
    pixel_t e_data;
    logic e_ov;
    vec_t tbl [15];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int b = 0; b < 2; b++)
            for (int c = 0; c < H_ACTIVE; c++) mb[b][c] = TRANSPARENT;
        m_sel = 0; m_seen = 0; p_v = 0; p_b = 0; p_c = '0; m_cnt = 0;
        e_data = TRANSPARENT; e_ov = 0;
    endtask

    // one clock of the line-buffer rules: read display line, clear what was shown, paint draw line
    task automatic m_step();
        pixel_t v;
        if (m_cnt < H_ACTIVE) begin
            m_cnt++;
            e_data = TRANSPARENT; e_ov = 0; p_v = 0;
            return;
        end
        v = (bus.rd_en && bus.rd_col < COL_END) ? mb[!m_sel][bus.rd_col] : TRANSPARENT;
        if (p_v && p_b != m_sel) mb[p_b][p_c] = TRANSPARENT;
        if (bus.wr_en && bus.wr_col < COL_END && bus.wr_data != TRANSPARENT)
            mb[m_sel][bus.wr_col] = bus.wr_data;
        p_v = bus.rd_en && bus.rd_col < COL_END;
        p_b = !m_sel;
        p_c = bus.rd_col;
        e_data = v;
        e_ov = bus.line_swap && !m_seen && !bus.draw_done;
        if (bus.line_swap) begin
            m_sel = !m_sel;
            m_seen = 0;
        end else if (bus.draw_done) m_seen = 1;
    endtask

    task automatic cyc(logic sw, logic dn, logic we, col_t wc, pixel_t wd, logic re, col_t rc);
        bus.line_swap = sw; bus.draw_done = dn; bus.wr_en = we; bus.wr_col = wc;
        bus.wr_data = wd; bus.rd_en = re; bus.rd_col = rc;
        if (sw && re && m_cnt >= H_ACTIVE) begin
            errs++;
            $display("FAIL contract: rd_en high in line_swap cycle at %0t", $time);
        end
        @(posedge clk);
        m_step();
        @(negedge clk);
        chk("rd_data", 32'(bus.rd_data), 32'(e_data));
        chk("rd_opaque", 32'(bus.rd_opaque), 32'(e_data != TRANSPARENT));
        chk("overrun", 32'(bus.overrun), 32'(e_ov));
        chk("ready", 32'(bus.ready), 32'(m_cnt >= H_ACTIVE));
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    function automatic vec_t mk(logic sw, logic dn, logic we, col_t wc, pixel_t wd,
                                logic re, col_t rc, pixel_t ed, logic eo, logic ev);
        vec_t v;
        v.sw = sw; v.dn = dn; v.we = we; v.wc = wc; v.wd = wd;
        v.re = re; v.rc = rc; v.ed = ed; v.eo = eo; v.ev = ev;
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = mk(1'b0, 1'b0, 1'b1, 10'd5,   16'hF800, 1'b0, 10'd0,   16'h0000, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 1'b0, 1'b1, 10'd6,   16'h0000, 1'b0, 10'd0,   16'h0000, 1'b0, 1'b0);
        tbl[2]  = mk(1'b0, 1'b0, 1'b1, 10'd700, 16'h07E0, 1'b0, 10'd0,   16'h0000, 1'b0, 1'b0);
        tbl[3]  = mk(1'b0, 1'b0, 1'b1, 10'd10,  16'h001F, 1'b0, 10'd0,   16'h0000, 1'b0, 1'b0);
        tbl[4]  = mk(1'b0, 1'b1, 1'b1, 10'd10,  16'hFFFF, 1'b0, 10'd0,   16'h0000, 1'b0, 1'b0);
        tbl[5]  = mk(1'b1, 1'b0, 1'b0, 10'd0,   16'h0000, 1'b0, 10'd0,   16'h0000, 1'b0, 1'b0);
        tbl[6]  = mk(1'b0, 1'b0, 1'b0, 10'd0,   16'h0000, 1'b1, 10'd5,   16'hF800, 1'b1, 1'b0);
        tbl[7]  = mk(1'b0, 1'b0, 1'b0, 10'd0,   16'h0000, 1'b1, 10'd6,   16'h0000, 1'b0, 1'b0);
        tbl[8]  = mk(1'b0, 1'b0, 1'b0, 10'd0,   16'h0000, 1'b1, 10'd700, 16'h0000, 1'b0, 1'b0);
        tbl[9]  = mk(1'b0, 1'b0, 1'b0, 10'd0,   16'h0000, 1'b1, 10'd10,  16'hFFFF, 1'b1, 1'b0);
        tbl[10] = mk(1'b0, 1'b0, 1'b0, 10'd0,   16'h0000, 1'b0, 10'd0,   16'h0000, 1'b0, 1'b0);
        tbl[11] = mk(1'b1, 1'b0, 1'b0, 10'd0,   16'h0000, 1'b0, 10'd0,   16'h0000, 1'b0, 1'b1);
        tbl[12] = mk(1'b0, 1'b0, 1'b0, 10'd0,   16'h0000, 1'b0, 10'd0,   16'h0000, 1'b0, 1'b0);
        tbl[13] = mk(1'b1, 1'b1, 1'b0, 10'd0,   16'h0000, 1'b0, 10'd0,   16'h0000, 1'b0, 1'b0);
        tbl[14] = mk(1'b0, 1'b0, 1'b0, 10'd0,   16'h0000, 1'b1, 10'd10,  16'h0000, 1'b0, 1'b0);

        bus.line_swap = 0; bus.draw_done = 0; bus.wr_en = 0; bus.wr_col = '0;
        bus.wr_data = '0; bus.rd_en = 0; bus.rd_col = '0;
        m_reset();
        #12;
        chk("reset_rd_data", 32'(bus.rd_data), 32'(TRANSPARENT));
        chk("reset_rd_opaque", 32'(bus.rd_opaque), 32'(0));
        chk("reset_ready", 32'(bus.ready), 32'(0));
        chk("reset_overrun", 32'(bus.overrun), 32'(0));
        @(negedge clk);
        reset = 1'b1;

        // init clear: ready must stay low for 639 cycles and rise after the 640th
        idle(H_ACTIVE - 1);
        chk("ready_before_641", 32'(bus.ready), 32'(0));
        idle(1);
        chk("ready_at_641", 32'(bus.ready), 32'(1));

        // both banks read back empty after the initial clear
        for (int c = 0; c < H_ACTIVE; c++) cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, col_t'(c));
        cyc(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, '0);
        for (int c = 0; c < H_ACTIVE; c++) cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, col_t'(c));
        idle(1);

        // directed vectors with hand-derived expectations
        for (int i = 0; i < 15; i++) begin
            cyc(tbl[i].sw, tbl[i].dn, tbl[i].we, tbl[i].wc, tbl[i].wd, tbl[i].re, tbl[i].rc);
            chk($sformatf("vec%0d_data", i), 32'(bus.rd_data), 32'(tbl[i].ed));
            chk($sformatf("vec%0d_opaque", i), 32'(bus.rd_opaque), 32'(tbl[i].eo));
            chk($sformatf("vec%0d_overrun", i), 32'(bus.overrun), 32'(tbl[i].ev));
        end

        // mid-line reset: outputs drop immediately, stored pixels are wiped by re-init
        cyc(1'b0, 1'b0, 1'b1, 10'd3, 16'h1234, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b1, 10'd20, 16'hABCD, 1'b0, '0);
        cyc(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 10'd20);
        chk("pre_reset_data", 32'(bus.rd_data), 32'(16'hABCD));
        #2 reset = 1'b0;
        #1;
        chk("async_rd_data", 32'(bus.rd_data), 32'(TRANSPARENT));
        chk("async_rd_opaque", 32'(bus.rd_opaque), 32'(0));
        chk("async_ready", 32'(bus.ready), 32'(0));
        m_reset();
        bus.rd_en = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        idle(H_ACTIVE);
        cyc(1'b1, 1'b1, 1'b0, '0, '0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 10'd3);
        chk("col3_after_reinit", 32'(bus.rd_data), 32'(TRANSPARENT));

        // randomized concurrent draw and scanout over several lines
        for (int l = 0; l < 5; l++) begin
            for (int c = 0; c < H_ACTIVE; c++) begin
                logic we, dn;
                col_t wc;
                pixel_t wd;
                we = $urandom_range(0, 3) != 0;
                wc = col_t'($urandom_range(0, 700));
                wd = ($urandom_range(0, 4) == 0) ? TRANSPARENT : pixel_t'($urandom);
                dn = (c == H_ACTIVE - 1) && (l != 2);
                cyc(1'b0, dn, we, wc, wd, 1'b1, col_t'(c));
            end
            cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0, '0, '0, 1'b0, '0);
        end
        for (int c = 0; c < H_ACTIVE; c++) cyc(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, col_t'(c));
        idle(2);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
